// File: rtl/wash_sequencer.sv
// wash_sequencer: fill/wash/drain cycle controller with prescaled phase counter
// Ports: clk, reset (sync, active-high); start, abort, preset_sel[1:0] front panel;
//   comp_time, comp_time2 comparator match flags; count[7:0], control_preset[1:0]
//   to comparator; fill_valve, motor_on, drain_pump actuators; busy, done, fault status.
module wash_sequencer #(
   parameter int PRESCALE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [1:0] preset_sel,
   input  logic       comp_time,
   input  logic       comp_time2,
   output logic [7:0] count,
   output logic [1:0] control_preset,
   output logic       fill_valve,
   output logic       motor_on,
   output logic       drain_pump,
   output logic       busy,
   output logic       done,
   output logic       fault
);
   localparam int PW = $clog2(PRESCALE);
   typedef enum logic [2:0] {IDLE, FILL, WASH, DRAIN, DONE, FAULT} state_t;
   state_t state, next;
   logic [PW-1:0] pre;
   logic tick, phase;
   assign phase = state == FILL || state == WASH || state == DRAIN;
   assign tick = pre == PW'(PRESCALE - 1);
   always_comb begin
      next = state;
      case (state)
         IDLE:  next = abort ? IDLE : start ? FILL : IDLE;
         FILL:  next = abort ? DRAIN : (tick && comp_time2) ? WASH : FILL;
         WASH:  next = abort ? DRAIN : (tick && comp_time) ? DRAIN :
                       (tick && count == 8'hff) ? FAULT : WASH;
         DRAIN: next = (tick && comp_time2) ? DONE : DRAIN;
         DONE:  next = IDLE;
         FAULT: next = abort ? IDLE : FAULT;
         default: next = IDLE;
      endcase
   end
   // Leaving a state restarts the phase timer; FAULT keeps the saturated count visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         count          <= '0;
         pre            <= '0;
         control_preset <= '0;
      end else begin
         state <= next;
         if (state == IDLE && next == FILL) control_preset <= preset_sel;
         if (next != state) begin
            pre <= '0;
            if (next != FAULT) count <= '0;
         end else if (phase) begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick && count != 8'hff) count <= count + 8'd1;
         end
      end
   end
   assign fill_valve = state == FILL;
   assign motor_on   = state == WASH;
   assign drain_pump = state == DRAIN;
   assign busy       = phase || state == DONE;
   assign done       = state == DONE;
   assign fault      = state == FAULT;
endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Cycle controller of the washing-machine datapath. It latches the wash preset at start, drives the 8-bit phase `count` and the registered `control_preset` to the time comparator, and consumes that comparator's `comp_time` and `comp_time2` match flags. It advances through fill, wash and drain phases and drives the valve, motor and pump enables. It sits between the front-panel inputs and the actuator outputs.

## Interface

**Parameters**
- `PRESCALE`, default 4: clock cycles per count unit (≥2).

**Ports**
- `clk` — in, 1: rising-edge clock.
- `reset` — in, 1: synchronous, active-high.
- `start` — in, 1: begin a cycle; level, sampled in IDLE only.
- `abort` — in, 1: abandon the cycle; level.
- `preset_sel` — in, 2: preset choice, sampled with `start`.
- `comp_time` — in, 1: wash-duration match flag from the comparator.
- `comp_time2` — in, 1: fill/drain-duration match flag (count == 5).
- `count` — out, 8: phase elapsed units.
- `control_preset` — out, 2: latched preset.
- `fill_valve` — out, 1: high in FILL.
- `motor_on` — out, 1: high in WASH.
- `drain_pump` — out, 1: high in DRAIN.
- `busy` — out, 1: high in FILL, WASH, DRAIN and DONE.
- `done` — out, 1: one-cycle pulse in DONE.
- `fault` — out, 1: high in FAULT.

## Operation

- States: IDLE, FILL, WASH, DRAIN, DONE, FAULT. All outputs are registered or decoded from the state register (Moore); no input reaches an output combinationally.
- Prescaler `pre` runs 0..PRESCALE-1 in FILL, WASH and DRAIN. `tick` = (`pre` == PRESCALE-1).
- Phase entry clears `count` and `pre` to 0.
- On each tick with no phase exit, `count` increments, saturating at 255 (no wrap).
- Match flags are evaluated only on tick cycles and only against the current registered `count`. The comparison happens before the increment.
- Transitions (priority top-down):
  - `reset`: IDLE, all registers 0.
  - IDLE: `abort` holds IDLE. Otherwise `start` goes to FILL and latches `control_preset` ← `preset_sel`.
  - FILL or WASH with `abort`: go to DRAIN.
  - FILL: tick && `comp_time2` goes to WASH.
  - WASH: tick && `comp_time` goes to DRAIN. Tick && !`comp_time` && `count` == 255 goes to FAULT.
  - DRAIN: tick && `comp_time2` goes to DONE. `abort` is ignored; the drain always completes.
  - DONE: next cycle goes to IDLE unconditionally.
  - FAULT: `abort` goes to IDLE. Otherwise hold. `count` freezes at 255.
- `control_preset` holds its value from start until the next accepted `start`; it is not cleared on return to IDLE.
- `start` asserted outside IDLE is ignored.
- A `start` held high through DONE begins a new cycle from IDLE (back-to-back cycles allowed).

## Timing

- Reset values: state IDLE; `count` = 0, `control_preset` = 0, `pre` = 0; every 1-bit output 0.
- Start latency: `start` high at edge N gives FILL/`fill_valve`/`busy` high after edge N. `count` = 0 at that point.
- Phase length with a matching comparator: (M+1)·PRESCALE cycles, where M is the match count value.
  - FILL and DRAIN: 6·PRESCALE cycles.
  - WASH with custom time W: (W+1)·PRESCALE cycles.
- Phase handover is 0-cycle: the last cycle of a phase is followed immediately by the next state with `count` = 0.
- `done` is high for exactly one cycle, then IDLE.
- Abort latency: abort in FILL or WASH sampled at edge N gives DRAIN after edge N, with `count` = 0.
- Reset mid-cycle: the next cycle is IDLE with all actuators off; no DONE pulse.

## Test plan

The bench models the comparator with `comp_time2` = (`count` == 5). `comp_time` by `control_preset`: 00 → `washing_time`, 01 → 10, 10 → 16, 11 → 21. `PRESCALE` = 4.

- Start with preset 01 → FILL 24 cycles; then WASH 44 cycles (`count` 0..10); then DRAIN 24 cycles; then `done` for 1 cycle; then IDLE. `busy` is high for 93 cycles.
- Preset 00 with `washing_time` = 0 → WASH lasts exactly 4 cycles; `count` stays 0 throughout.
- Abort at WASH `count` = 7 → DRAIN the next cycle with `count` = 0; DRAIN completes in 24 cycles; `done` pulses. Abort asserted during DRAIN has no effect.
- Comparator `comp_time` forced 0 in WASH → `count` saturates at 255; FAULT at tick of `count` 255 (cycle 1024 of WASH); `fault` = 1, `motor_on` = 0; `abort` → IDLE.
- `start` pulsed during WASH with a different `preset_sel` → ignored; `control_preset` unchanged. `start` and `abort` together in IDLE → remains IDLE.
- `reset` asserted mid-FILL → the next cycle shows all outputs 0. A subsequent `start` gives a full normal cycle.
